dadda_mac_sched: RTL and testbench

//  Sequencer for the 8x8 Dadda multiply-accumulate datapath (dadda tree + 16-bit carry-select final adder).

---
 rtl/dadda_mac_sched.sv | 145 ++++++++++++++
 tb/tb_dadda_mac_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mac_sched.sv
// dadda_mac_sched: sequences operand pairs through an external 8x8 Dadda multiply-accumulate datapath.
// Optional build macro DADDA_MAC_SATURATE_EN clamps the accumulator at 16'hFFFF after the first carry-out.
module dadda_mac_sched #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic [7:0]       dp_inp1,
    output logic [7:0]       dp_inp2,
    output logic [15:0]      dp_acc,
    input  logic [16:0]      dp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_ovf,
    output logic [LEN_W-1:0] out_count,
    output logic             busy
);

    localparam int unsigned OP_W  = 8;
    localparam int unsigned ACC_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  settle_cnt;
    logic              last_flag;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic              ovf_nxt;
    logic              release_res;

    assign release_res = out_valid && out_ready;
    assign dp_acc      = acc;
    assign out_data    = acc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = last_flag ? DONE : IDLE;
            DONE:    if (release_res) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        if (state == IDLE) begin
            in_ready = 1'b1;
            busy     = 1'b0;
        end
    end

    // Accumulator update taken from the settled final-adder sum
    always_comb begin
        ovf_nxt = out_ovf | dp_result[16];
`ifdef DADDA_MAC_SATURATE_EN
        acc_nxt = ovf_nxt ? {ACC_W{1'b1}} : dp_result[ACC_W-1:0];
`else
        acc_nxt = dp_result[ACC_W-1:0];
`endif
    end

    // Operand, counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_inp1    <= '0;
            dp_inp2    <= '0;
            acc        <= '0;
            out_ovf    <= 1'b0;
            out_count  <= '0;
            settle_cnt <= '0;
            last_flag  <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dp_inp1    <= OP_W'(in_a);
                        dp_inp2    <= OP_W'(in_b);
                        last_flag  <= in_last;
                        settle_cnt <= CNT_W'(SETTLE_CYC - 1);
                    end
                end
                SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    acc     <= acc_nxt;
                    out_ovf <= ovf_nxt;
                    if (out_count != {LEN_W{1'b1}}) begin
                        out_count <= out_count + 1'b1;
                    end
                end
                DONE: begin
                    // Valid asserts one cycle into DONE and holds until the consumer takes it
                    if (release_res) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        out_ovf   <= 1'b0;
                        out_count <= '0;
                        dp_inp1   <= '0;
                        dp_inp2   <= '0;
                        last_flag <= 1'b0;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dadda_mac_sched.sv
// tb_dadda_mac_sched: checks the MAC sequencer against a plain-arithmetic dot-product model.
// Three instances (SETTLE_CYC = 4, 1, 15) each drive a datapath model that outputs junk until settled.
`timescale 1ns/1ps
module tb_dadda_mac_sched;

    localparam int unsigned NI    = 3;
    localparam int unsigned LEN_W = 8;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic             rst       [NI];
    logic             in_valid  [NI];
    logic [7:0]       in_a      [NI];
    logic [7:0]       in_b      [NI];
    logic             in_last   [NI];
    logic             out_ready [NI];
    logic             in_ready  [NI];
    logic [7:0]       dp_inp1   [NI];
    logic [7:0]       dp_inp2   [NI];
    logic [15:0]      dp_acc    [NI];
    logic             out_valid [NI];
    logic [15:0]      out_data  [NI];
    logic             out_ovf   [NI];
    logic [LEN_W-1:0] out_count [NI];
    logic             busy      [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int SG = (g == 0) ? 4 : ((g == 1) ? 1 : 15);
        logic [16:0] dp_result = '0;
        logic [31:0] prev_in = '0;
        int          stable = 0;
        logic [31:0] cur_in;
        logic        changed;
        int          st_n;

        assign cur_in  = {dp_inp1[g], dp_inp2[g], dp_acc[g]};
        assign changed = (cur_in != prev_in);
        assign st_n    = changed ? 0 : ((stable < 1000) ? stable + 1 : stable);

        // Datapath: correct sum only after SG-1 stable cycles, garbage before
        always @(negedge clk) begin
            prev_in <= cur_in;
            stable  <= st_n;
            if (st_n >= SG - 1)
                dp_result <= 17'(dp_acc[g]) + 17'(dp_inp1[g]) * 17'(dp_inp2[g]);
            else
                dp_result <= 17'($urandom);
        end

        dadda_mac_sched #(
            .SETTLE_CYC(SG),
            .CNT_W     (4),
            .LEN_W     (LEN_W)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_a     (in_a[g]),
            .in_b     (in_b[g]),
            .in_last  (in_last[g]),
            .dp_inp1  (dp_inp1[g]),
            .dp_inp2  (dp_inp2[g]),
            .dp_acc   (dp_acc[g]),
            .dp_result(dp_result),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .out_ovf  (out_ovf[g]),
            .out_count(out_count[g]),
            .busy     (busy[g])
        );
    end

    function automatic int unsigned settle_of(int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 15);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: running dot product of the current vector
    int unsigned m_acc = 0;
    bit          m_ovf = 0;
    int unsigned m_cnt = 0;

    task automatic model_clear();
        m_acc = 0;
        m_ovf = 0;
        m_cnt = 0;
    endtask

    task automatic model_add(int unsigned a, int unsigned b);
        int unsigned t;
        t = m_acc + a * b;
        if (t > 65535) m_ovf = 1;
`ifdef DADDA_MAC_SATURATE_EN
        m_acc = m_ovf ? 65535 : t % 65536;
`else
        m_acc = t % 65536;
`endif
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic send_pair(int k, logic [7:0] a, logic [7:0] b, logic last,
                             output int unsigned c0);
        int n;
        n = 0;
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_a[k]     = a;
        in_b[k]     = b;
        in_last[k]  = last;
        while (!in_ready[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(in_ready[k]), 1);
        @(posedge clk);
        #1;
        c0 = cyc;
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
        model_add(32'(a), 32'(b));
    endtask

    task automatic wait_result(int k, int unsigned c0, string tag, bit chk_lat, int hold);
        int          n;
        logic [15:0] held;
        n = 0;
        out_ready[k] = (hold == 0);
        @(negedge clk);
        while (!out_valid[k] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid[k]), 1);
        if (chk_lat) check({tag, "_lat"}, cyc - c0, settle_of(k) + 2);
        check({tag, "_data"}, 32'(out_data[k]), m_acc);
        check({tag, "_ovf"}, 32'(out_ovf[k]), 32'(m_ovf));
        check({tag, "_count"}, 32'(out_count[k]), m_cnt);
        held = out_data[k];
        for (int i = 0; i < hold; i++) begin
            in_valid[k] = 1'($urandom);
            in_a[k]     = 8'($urandom);
            in_b[k]     = 8'($urandom);
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid[k]), 1);
            check({tag, "_hold_data"}, 32'(out_data[k]), 32'(held));
            check({tag, "_hold_inready"}, 32'(in_ready[k]), 0);
        end
        if (hold > 0) check({tag, "_hold_count"}, 32'(out_count[k]), m_cnt);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_drop"}, 32'(out_valid[k]), 0);
        check({tag, "_clr_data"}, 32'(out_data[k]), 0);
        check({tag, "_clr_count"}, 32'(out_count[k]), 0);
        check({tag, "_idle_ready"}, 32'(in_ready[k]), 1);
        model_clear();
    endtask

    task automatic reset_check(int k, string tag);
        check({tag, "_in_ready"}, 32'(in_ready[k]), 1);
        check({tag, "_out_valid"}, 32'(out_valid[k]), 0);
        check({tag, "_busy"}, 32'(busy[k]), 0);
        check({tag, "_dp_inp"}, {16'(dp_inp1[k]), 16'(dp_inp2[k])}, 0);
        check({tag, "_dp_acc"}, 32'(dp_acc[k]), 0);
        check({tag, "_out_data"}, 32'(out_data[k]), 0);
        check({tag, "_out_ovf"}, 32'(out_ovf[k]), 0);
        check({tag, "_out_count"}, 32'(out_count[k]), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int          len;
        int          hold;
        logic [7:0]  a;
        logic [7:0]  b;

        for (int k = 0; k < NI; k++) begin
            rst[k]       = 1'b1;
            in_valid[k]  = 1'b0;
            in_a[k]      = '0;
            in_b[k]      = '0;
            in_last[k]   = 1'b0;
            out_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        @(negedge clk);
        reset_check(0, "rst");

        // Two-term vector
        model_clear();
        send_pair(0, 8'd3, 8'd4, 1'b0, c0);
        send_pair(0, 8'd5, 8'd6, 1'b1, c0);
        wait_result(0, c0, "t1", 1'b1, 0);

        // Single-term vector, largest product
        send_pair(0, 8'd255, 8'd255, 1'b1, c0);
        wait_result(0, c0, "t2", 1'b1, 0);

        // Carry out of bit 15
        send_pair(0, 8'd255, 8'd255, 1'b0, c0);
        send_pair(0, 8'd255, 8'd255, 1'b1, c0);
        wait_result(0, c0, "t3", 1'b1, 0);

        // Long back-pressure with in_valid noise, then a fresh vector
        send_pair(0, 8'd9, 8'd9, 1'b1, c0);
        wait_result(0, c0, "t4_bp", 1'b1, 20);
        send_pair(0, 8'd2, 8'd2, 1'b1, c0);
        wait_result(0, c0, "t4_next", 1'b1, 0);

        // Reset in the middle of the second term's settle window
        send_pair(0, 8'd10, 8'd10, 1'b0, c0);
        send_pair(0, 8'd7, 8'd7, 1'b1, c0);
        @(negedge clk);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        reset_check(0, "t5_rst");
        model_clear();
        send_pair(0, 8'd1, 8'd1, 1'b1, c0);
        wait_result(0, c0, "t5_next", 1'b1, 0);

        // Random vectors, mixed operand ranges and back-pressure
        for (int v = 0; v < 10; v++) begin
            len  = int'($urandom_range(1, 4));
            hold = int'($urandom_range(0, 3));
            for (int t = 0; t < len; t++) begin
                if ($urandom_range(0, 1) == 1) begin
                    a = 8'($urandom_range(200, 255));
                    b = 8'($urandom_range(200, 255));
                end else begin
                    a = 8'($urandom);
                    b = 8'($urandom);
                end
                send_pair(0, a, b, 1'(t == len - 1), c0);
            end
            wait_result(0, c0, "rnd", 1'b1, hold);
        end

        // Settle-time extremes
        for (int k = 1; k < NI; k++) begin
            send_pair(k, 8'd12, 8'd13, 1'b0, c0);
            send_pair(k, 8'd14, 8'd15, 1'b1, c0);
            wait_result(k, c0, (k == 1) ? "t6_s1" : "t6_s15", 1'b1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
